// File: rtl/gbsha_fir_top.sv
// gbsha_fir_top: pin-packed chip wrapper around a fixed-coefficient FIR low-pass filter.
//
// The filter is symmetric. Its coefficients are c_k = min(k+1, N_TAPS-k), which gives
// 1,2,3,4,5,5,4,3,2,1 at the default depth. The accumulator is exact. It is arithmetically
// shifted right by SHIFT and then saturated to a BW_out-bit signed result.
//
// Ports:
//   io_in[0]        clk    rising-edge clock
//   io_in[1]        rst_n  asynchronous active-low reset
//   io_in[7:2]      x_in   signed input sample (BW_in LSBs used)
//   io_out[BW_out-1:0]     signed filtered output, registered
//   io_out[7:BW_out]       constant 0
//
// Build option:
//   FIR_ROUND_EN   add 2^(SHIFT-1) before the shift (round half up) instead of plain floor.
module gbsha_fir_top #(
  parameter int unsigned N_TAPS = 10,
  parameter int unsigned BW_in  = 6,
  parameter int unsigned BW_out = 6,
  parameter int unsigned SHIFT  = 5
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  function automatic int coef_int(int k);
    int a;
    int b;
    a = k + 1;
    b = int'(N_TAPS) - k;
    return (a < b) ? a : b;
  endfunction

  function automatic int coef_sum();
    int s;
    s = 0;
    for (int k = 0; k < int'(N_TAPS); k++) begin
      s += coef_int(k);
    end
    return s;
  endfunction

  // Sign bit + sample magnitude + headroom for the coefficient sum (and rounding bias).
  localparam int unsigned AccW = BW_in + $clog2(coef_sum() + 1) + 1;

  localparam int YMaxInt = (1 << (BW_out - 1)) - 1;
  localparam int YMinInt = -YMaxInt - 1;
  localparam logic signed [AccW-1:0] YMax = AccW'(YMaxInt);
  localparam logic signed [AccW-1:0] YMin = AccW'(YMinInt);

  logic clk;
  logic rst_n;
  logic signed [BW_in-1:0] x_in;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign x_in  = io_in[2 +: BW_in];

  logic signed [BW_in-1:0]  d_q [N_TAPS];
  logic signed [BW_out-1:0] y_q;
  logic signed [BW_out-1:0] y_d;

  logic signed [AccW-1:0] acc;
  logic signed [AccW-1:0] acc_r;
  logic signed [AccW-1:0] shifted;
  logic signed [AccW-1:0] tap;

  // Multiply-accumulate over the pre-edge delay line.
  always_comb begin
    acc = '0;
    tap = '0;
    for (int k = 0; k < int'(N_TAPS); k++) begin
      tap = d_q[k];  // sign-extends to the accumulator width
      acc = acc + tap * AccW'(coef_int(k));
    end
  end

`ifdef FIR_ROUND_EN
  localparam logic signed [AccW-1:0] RoundBias = AccW'(1 << (SHIFT - 1));
  assign acc_r = acc + RoundBias;
`else
  assign acc_r = acc;
`endif

  always_comb begin
    shifted = acc_r >>> SHIFT;
    if (shifted > YMax) begin
      y_d = YMax[BW_out-1:0];
    end else if (shifted < YMin) begin
      y_d = YMin[BW_out-1:0];
    end else begin
      y_d = shifted[BW_out-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(N_TAPS); k++) begin
        d_q[k] <= '0;
      end
      y_q <= '0;
    end else begin
      d_q[0] <= x_in;
      for (int k = 1; k < int'(N_TAPS); k++) begin
        d_q[k] <= d_q[k-1];
      end
      y_q <= y_d;
    end
  end

  always_comb begin
    io_out = '0;
    io_out[BW_out-1:0] = y_q;
  end

endmodule

// File: tb/tb_gbsha_fir_top.sv
module tb_gbsha_fir_top;

  logic              clk;
  logic              rst_n;
  logic signed [5:0] x;
  logic [7:0]        io_in;
  logic [7:0]        io_out;

  assign io_in = {x, rst_n, clk};

  gbsha_fir_top dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int hist [10];
  int coef [10] = '{1, 2, 3, 4, 5, 5, 4, 3, 2, 1};
  int exp_q [$];
  int obs_log [$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference output produced by the next edge, from the current history.
  function automatic int model_y();
    int acc;
    int s;
    acc = 0;
    for (int k = 0; k < 10; k++) acc += coef[k] * hist[k];
`ifdef FIR_ROUND_EN
    acc += 16;
`endif
    s = acc >>> 5;
    if (s > 31) s = 31;
    if (s < -32) s = -32;
    return s;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 10; k++) hist[k] = 0;
  endfunction

  // Called at a negedge: drive one sample, push its expectation, check after the posedge,
  // and return at the following negedge.
  task automatic drive(input int xv, output int y);
    int e;
    x = 6'(xv);
    exp_q.push_back(model_y());
    for (int k = 9; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = xv;
    @(posedge clk);
    #1;
    y = int'($signed(io_out[5:0]));
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("scoreboard", y, e);
    end
    check("io_out_hi", int'(io_out[7:6]), 0);
    @(negedge clk);
  endtask

  int y;
  int v;
  int imp_exp [10];

  initial begin
    checks = 0;
    errors = 0;
    model_clear();
    rst_n = 1'b0;
    x = '0;

`ifdef FIR_ROUND_EN
    imp_exp = '{1, 2, 3, 4, 5, 5, 4, 3, 2, 1};
`else
    imp_exp = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0};
`endif

    // Reset held while clocking random samples.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      x = 6'($urandom_range(0, 63));
      #2;
      check("reset_hold", int'(io_out), 0);
    end
    @(negedge clk);
    x = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, y);
      check("post_reset_zero", y, 0);
    end

    // Impulse response.
    drive(31, y);
    check("impulse_e0", y, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, y);
      check($sformatf("impulse_e%0d", i + 1), y, imp_exp[i]);
    end
    drive(0, y);
    check("impulse_tail", y, 0);

    // Positive step.
    for (int i = 0; i < 12; i++) drive(31, y);
    check("step_pos", y, 29);

    // Negative step.
    for (int i = 0; i < 12; i++) drive(-32, y);
    check("step_neg", y, -30);
    check("step_neg_raw", int'(io_out), 8'h22);

    // Mid-run reset during a +31 stream.
    for (int i = 0; i < 12; i++) drive(31, y);
    check("pre_reset_level", y, 29);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", int'(io_out), 0);
    model_clear();
    @(negedge clk);
    check("reset_held_edge", int'(io_out), 0);
    rst_n = 1'b1;
    drive(31, y);
    check("ramp_first", y, 0);
    for (int i = 0; i < 11; i++) drive(31, y);
    check("ramp_settled", y, 29);

    // Alternating extremes.
    for (int i = 0; i < 40; i++) begin
      drive((i % 2 == 0) ? 31 : -32, y);
      if (y > 31 || y < -32) check("alt_bounds", y, 0);
    end

    // Random samples.
    for (int i = 0; i < 60; i++) begin
      v = int'($urandom_range(0, 63));
      if (v > 31) v -= 64;
      drive(v, y);
    end

    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
